// File: rtl/canvas_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : canvas_write_scheduler
// Description : Arbitrates the shared canvas write path between the live
//               drawing tool (priority, never stalled) and a raster clear
//               engine that sweeps one layer or all four layers.
// Revision    : 1.0 - initial release
// ============================================================================
module canvas_write_scheduler #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COLOR_WIDTH = 4,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tool_valid,
    input  logic [$clog2(WIDTH)-1:0]   tool_x,
    input  logic [$clog2(HEIGHT)-1:0]  tool_y,
    input  logic [COLOR_WIDTH-1:0]     tool_color,
    input  logic [2:0]                 tool_layer,
    input  logic [3:0]                 layer_visible,
    input  logic                       clear_req,
    input  logic [2:0]                 clear_layer,
    input  logic                       clear_all,
    output logic [3:0]                 write_en,
    output logic [$clog2(WIDTH)-1:0]   write_x,
    output logic [$clog2(HEIGHT)-1:0]  write_y,
    output logic [COLOR_WIDTH-1:0]     write_color,
    output logic                       busy,
    output logic                       clear_done,
    output logic                       tool_dropped
);

    localparam int c_X_W = $clog2(WIDTH);
    localparam int c_Y_W = $clog2(HEIGHT);

    localparam logic [c_X_W-1:0]       c_X_LAST    = c_X_W'(WIDTH - 1);
    localparam logic [c_Y_W-1:0]       c_Y_LAST    = c_Y_W'(HEIGHT - 1);
    localparam logic [c_X_W-1:0]       c_X_ONE     = c_X_W'(1);
    localparam logic [c_Y_W-1:0]       c_Y_ONE     = c_Y_W'(1);
    localparam logic [COLOR_WIDTH-1:0] c_CLR_COLOR = COLOR_WIDTH'(CLEAR_COLOR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Layer number 1..4 to its write-enable bit; anything else selects nothing.
    function automatic logic [3:0] f_layer_onehot(input logic [2:0] layer);
        logic [3:0] v_mask;
        case (layer)
            3'd1:    v_mask = 4'b0001;
            3'd2:    v_mask = 4'b0010;
            3'd3:    v_mask = 4'b0100;
            3'd4:    v_mask = 4'b1000;
            default: v_mask = 4'b0000;
        endcase
        return v_mask;
    endfunction

    state_t                 r_state_q,        w_state_d;
    logic [c_X_W-1:0]       r_cx_q,           w_cx_d;
    logic [c_Y_W-1:0]       r_cy_q,           w_cy_d;
    logic [3:0]             r_clear_mask_q,   w_clear_mask_d;
    logic [3:0]             r_write_en_q,     w_write_en_d;
    logic [c_X_W-1:0]       r_write_x_q,      w_write_x_d;
    logic [c_Y_W-1:0]       r_write_y_q,      w_write_y_d;
    logic [COLOR_WIDTH-1:0] r_write_color_q,  w_write_color_d;
    logic                   r_busy_q,         w_busy_d;
    logic                   r_clear_done_q,   w_clear_done_d;
    logic                   r_tool_dropped_q, w_tool_dropped_d;

    logic [3:0] w_active_clear_mask;
    logic [3:0] w_tool_mask;
    logic       w_tool_grant;
    logic [3:0] w_req_mask;

    // Layers under an active sweep are locked out of the tool so a fresh
    // stroke cannot be erased by a later pass of the clear engine.
    assign w_active_clear_mask = (r_state_q == S_CLEAR) ? r_clear_mask_q : 4'b0000;
    assign w_tool_mask         = f_layer_onehot(tool_layer) & layer_visible & ~w_active_clear_mask;
    assign w_tool_grant        = tool_valid && (w_tool_mask != 4'b0000);
    assign w_req_mask          = clear_all ? 4'b1111 : f_layer_onehot(clear_layer);

    always_comb begin
        w_state_d        = r_state_q;
        w_cx_d           = r_cx_q;
        w_cy_d           = r_cy_q;
        w_clear_mask_d   = r_clear_mask_q;
        w_write_en_d     = 4'b0000;
        w_write_x_d      = '0;
        w_write_y_d      = '0;
        w_write_color_d  = '0;
        w_busy_d         = (r_state_q == S_CLEAR);
        w_clear_done_d   = (r_state_q == S_DONE);
        w_tool_dropped_d = tool_valid && !w_tool_grant;

        if (w_tool_grant) begin
            w_write_en_d    = w_tool_mask;
            w_write_x_d     = tool_x;
            w_write_y_d     = tool_y;
            w_write_color_d = tool_color;
        end

        case (r_state_q)
            S_IDLE: begin
                if (clear_req && (w_req_mask != 4'b0000)) begin
                    w_state_d      = S_CLEAR;
                    w_cx_d         = '0;
                    w_cy_d         = '0;
                    w_clear_mask_d = w_req_mask;
                end
            end

            S_CLEAR: begin
                // The sweep only uses slots the tool did not win; a granted
                // tool write holds the raster position for one cycle.
                if (!w_tool_grant) begin
                    w_write_en_d    = r_clear_mask_q;
                    w_write_x_d     = r_cx_q;
                    w_write_y_d     = r_cy_q;
                    w_write_color_d = c_CLR_COLOR;
                    if (r_cx_q == c_X_LAST) begin
                        w_cx_d = '0;
                        if (r_cy_q == c_Y_LAST) begin
                            w_cy_d    = '0;
                            w_state_d = S_DONE;
                        end else begin
                            w_cy_d = r_cy_q + c_Y_ONE;
                        end
                    end else begin
                        w_cx_d = r_cx_q + c_X_ONE;
                    end
                end
            end

            S_DONE: begin
                w_state_d      = S_IDLE;
                w_clear_mask_d = 4'b0000;
            end

            default: begin
                w_state_d      = S_IDLE;
                w_clear_mask_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q        <= S_IDLE;
            r_cx_q           <= '0;
            r_cy_q           <= '0;
            r_clear_mask_q   <= 4'b0000;
            r_write_en_q     <= 4'b0000;
            r_write_x_q      <= '0;
            r_write_y_q      <= '0;
            r_write_color_q  <= '0;
            r_busy_q         <= 1'b0;
            r_clear_done_q   <= 1'b0;
            r_tool_dropped_q <= 1'b0;
        end else begin
            r_state_q        <= w_state_d;
            r_cx_q           <= w_cx_d;
            r_cy_q           <= w_cy_d;
            r_clear_mask_q   <= w_clear_mask_d;
            r_write_en_q     <= w_write_en_d;
            r_write_x_q      <= w_write_x_d;
            r_write_y_q      <= w_write_y_d;
            r_write_color_q  <= w_write_color_d;
            r_busy_q         <= w_busy_d;
            r_clear_done_q   <= w_clear_done_d;
            r_tool_dropped_q <= w_tool_dropped_d;
        end
    end

    assign write_en     = r_write_en_q;
    assign write_x      = r_write_x_q;
    assign write_y      = r_write_y_q;
    assign write_color  = r_write_color_q;
    assign busy         = r_busy_q;
    assign clear_done   = r_clear_done_q;
    assign tool_dropped = r_tool_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_canvas_write_scheduler
// Description : Scoreboard bench for canvas_write_scheduler on an 8x8 canvas;
//               a linear-index reference model predicts every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_canvas_write_scheduler;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int CW    = 4;
    localparam int CLEAR = 0;

    logic          clk;
    logic          reset;
    logic          tool_valid;
    logic [2:0]    tool_x;
    logic [2:0]    tool_y;
    logic [CW-1:0] tool_color;
    logic [2:0]    tool_layer;
    logic [3:0]    layer_visible;
    logic          clear_req;
    logic [2:0]    clear_layer;
    logic          clear_all;
    logic [3:0]    write_en;
    logic [2:0]    write_x;
    logic [2:0]    write_y;
    logic [CW-1:0] write_color;
    logic          busy;
    logic          clear_done;
    logic          tool_dropped;

    canvas_write_scheduler #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .COLOR_WIDTH (CW),
        .CLEAR_COLOR (CLEAR)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .tool_valid    (tool_valid),
        .tool_x        (tool_x),
        .tool_y        (tool_y),
        .tool_color    (tool_color),
        .tool_layer    (tool_layer),
        .layer_visible (layer_visible),
        .clear_req     (clear_req),
        .clear_layer   (clear_layer),
        .clear_all     (clear_all),
        .write_en      (write_en),
        .write_x       (write_x),
        .write_y       (write_y),
        .write_color   (write_color),
        .busy          (busy),
        .clear_done    (clear_done),
        .tool_dropped  (tool_dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]    we;
        logic [2:0]    x;
        logic [2:0]    y;
        logic [CW-1:0] c;
        logic          busy;
        logic          done;
        logic          drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   out_idx;

    // Reference state: a clear is either sweeping a linear pixel index,
    // reporting completion for one cycle, or absent.
    bit         m_sweeping;
    bit         m_finishing;
    int         m_pos;
    logic [3:0] m_mask;

    function automatic logic [3:0] layer_bit(input int l);
        logic [3:0] v;
        v = 4'b0000;
        if (l >= 1 && l <= 4) v[l-1] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        exp_t       e;
        logic [3:0] tm;
        logic [3:0] req;
        bit         granted;
        e = '0;
        if (reset) begin
            m_sweeping  = 0;
            m_finishing = 0;
            m_pos       = 0;
            m_mask      = 4'b0000;
        end else begin
            tm      = layer_bit(int'(tool_layer)) & layer_visible & (m_sweeping ? ~m_mask : 4'hF);
            granted = tool_valid && (tm != 4'b0000);
            if (granted) begin
                e.we = tm;
                e.x  = tool_x;
                e.y  = tool_y;
                e.c  = tool_color;
            end else if (tool_valid) begin
                e.drop = 1'b1;
            end
            e.busy = m_sweeping;
            e.done = m_finishing;
            if (m_sweeping) begin
                if (!granted) begin
                    e.we  = m_mask;
                    e.x   = 3'(m_pos % W);
                    e.y   = 3'(m_pos / W);
                    e.c   = CW'(CLEAR);
                    m_pos = m_pos + 1;
                    if (m_pos == W * H) begin
                        m_sweeping  = 0;
                        m_finishing = 1;
                    end
                end
            end else if (m_finishing) begin
                m_finishing = 0;
            end else if (clear_req) begin
                req = clear_all ? 4'b1111 : layer_bit(int'(clear_layer));
                if (req != 4'b0000) begin
                    m_sweeping = 1;
                    m_pos      = 0;
                    m_mask     = req;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Inputs are set at a negedge; the model predicts the outputs that appear
    // after the following posedge, then we wait for the next negedge.
    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic start_clear(input int layer, input bit all);
        clear_req   = 1'b1;
        clear_layer = 3'(layer);
        clear_all   = all;
        cycle();
        clear_req   = 1'b0;
        clear_all   = 1'b0;
    endtask

    // Runs a clear while poking tool writes to tool layer tl at sweep
    // positions 10 and 11, then lets it finish.
    task automatic clear_with_tool(input int tl);
        bit f10;
        bit f11;
        f10 = 0;
        f11 = 0;
        for (int i = 0; i < 80; i++) begin
            tool_valid = 1'b0;
            if (m_sweeping && m_pos == 10 && !f10) begin
                tool_valid = 1'b1;
                f10 = 1;
            end else if (m_sweeping && m_pos == 11 && !f11) begin
                tool_valid = 1'b1;
                f11 = 1;
            end
            tool_layer = 3'(tl);
            tool_x     = 3'(i);
            tool_y     = 3'(7 - (i % 8));
            tool_color = 4'hA;
            cycle();
        end
        tool_valid = 1'b0;
    endtask

    exp_t mon_e;
    bit   mon_ok;

    initial begin
        out_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                mon_ok = (write_en === mon_e.we) && (busy === mon_e.busy) &&
                         (clear_done === mon_e.done) && (tool_dropped === mon_e.drop);
                if (mon_e.we != 4'b0000)
                    mon_ok = mon_ok && (write_x === mon_e.x) && (write_y === mon_e.y) &&
                             (write_color === mon_e.c);
                n_checks++;
                if (!mon_ok) begin
                    n_fail++;
                    $display("FAIL out[%0d] t=%0t: got we=%b x=%0d y=%0d c=%0d busy=%b done=%b drop=%b, expected we=%b x=%0d y=%0d c=%0d busy=%b done=%b drop=%b",
                             out_idx, $time, write_en, write_x, write_y, write_color, busy, clear_done, tool_dropped,
                             mon_e.we, mon_e.x, mon_e.y, mon_e.c, mon_e.busy, mon_e.done, mon_e.drop);
                end
                out_idx++;
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        m_sweeping    = 0;
        m_finishing   = 0;
        m_pos         = 0;
        m_mask        = 4'b0000;
        reset         = 1'b1;
        tool_valid    = 1'b0;
        tool_x        = '0;
        tool_y        = '0;
        tool_color    = '0;
        tool_layer    = '0;
        layer_visible = 4'b0000;
        clear_req     = 1'b0;
        clear_layer   = '0;
        clear_all     = 1'b0;
        @(negedge clk);

        // Reset state, then a single granted tool write.
        run(2);
        reset         = 1'b0;
        layer_visible = 4'b0010;
        tool_valid    = 1'b1;
        tool_layer    = 3'd2;
        tool_x        = 3'd3;
        tool_y        = 3'd5;
        tool_color    = 4'd6;
        cycle();

        // Invisible layer, then no layer at all: both dropped.
        tool_layer = 3'd3;
        cycle();
        tool_layer = 3'd0;
        cycle();
        tool_valid = 1'b0;
        run(2);

        // Uncontended single-layer clear.
        start_clear(1, 0);
        run(70);

        // Clear all layers: tool writes to layer 2 are locked out.
        start_clear(0, 1);
        clear_with_tool(2);

        // Clear layer 1: tool writes to visible layer 4 win and stall the sweep.
        layer_visible = 4'b1010;
        start_clear(1, 0);
        clear_with_tool(4);

        // Reset in the middle of a sweep, then a fresh clear.
        start_clear(2, 0);
        for (int i = 0; i < 40 && !(m_sweeping && m_pos == 20); i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(5);
        start_clear(2, 0);
        run(70);

        // Bad clear layer ignored; a second request mid-clear ignored.
        start_clear(5, 0);
        run(3);
        start_clear(0, 0);
        run(3);
        start_clear(3, 0);
        run(10);
        start_clear(4, 1);
        run(70);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            tool_valid  = 1'($urandom_range(0, 1));
            tool_layer  = 3'($urandom_range(0, 7));
            tool_x      = 3'($urandom_range(0, 7));
            tool_y      = 3'($urandom_range(0, 7));
            tool_color  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) layer_visible = 4'($urandom_range(0, 15));
            clear_req   = ($urandom_range(0, 19) == 0);
            clear_layer = 3'($urandom_range(0, 5));
            clear_all   = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 599) == 0);
            cycle();
        end
        reset      = 1'b0;
        tool_valid = 1'b0;
        clear_req  = 1'b0;
        clear_all  = 1'b0;
        run(2);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/canvas_write_scheduler.md
Name: canvas_write_scheduler

Overview:
Single owner of the write side of the four drawing canvases. Shares the canvas write path between two requesters: the live drawing tool, which has priority and is never stalled, and a built-in clear engine that sweeps every pixel of one layer or all layers. Drives per-layer write enables plus shared x, y and colour buses that fan out to all four canvases.

Parameters:
WIDTH, 640, canvas width in pixels.
HEIGHT, 480, canvas height in pixels.
COLOR_WIDTH, 4, colour index width.
CLEAR_COLOR, 0, colour index written by the clear engine (transparent).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tool_valid  in  1  tool write request, this cycle only
tool_x  in  $clog2(WIDTH)  tool pixel x
tool_y  in  $clog2(HEIGHT)  tool pixel y
tool_color  in  COLOR_WIDTH  tool pixel colour
tool_layer  in  3  target layer 1..4; 0 or >4 means none
layer_visible  in  4  bit i-1 set = layer i visible
clear_req  in  1  start clear, sampled in IDLE only
clear_layer  in  3  layer to clear, 1..4
clear_all  in  1  with clear_req: clear all four layers (overrides clear_layer)
write_en  out  4  bit i-1 = write layer i this cycle
write_x  out  $clog2(WIDTH)  write pixel x
write_y  out  $clog2(HEIGHT)  write pixel y
write_color  out  COLOR_WIDTH  write colour
busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse when a clear completes
tool_dropped  out  1  one-cycle pulse when a tool request is rejected

Behaviour:
- Reset: state=IDLE, all outputs 0, sweep counters 0, target mask 0. Reset during a clear aborts it; no clear_done is produced.
- All outputs are registered. Request sampled at edge k appears on the outputs after edge k+1 (latency 1).
- Tool path, any state:
  - eligible mask = onehot(tool_layer) & layer_visible & ~clear_mask (clear_mask is 0 outside CLEAR).
  - tool_valid with nonzero mask: write_en=mask, write_x/write_y/write_color=tool inputs.
  - tool_valid with zero mask (invalid layer, invisible layer, or layer being cleared): tool_dropped=1 and no tool write. The clear engine may use that slot.
- States:
  - IDLE: on clear_req, form clear_mask: clear_all gives 4'b1111; else onehot(clear_layer). If clear_layer is 0 or >4 and clear_all=0, ignore the request and stay in IDLE. Otherwise set cx=cy=0 and go to CLEAR; busy=1 from the next edge.
  - CLEAR: each cycle without a granted tool write, output write_en=clear_mask, (cx,cy), CLEAR_COLOR, then advance. cx increments; at WIDTH-1 it wraps to 0 and cy increments. The write at (WIDTH-1,HEIGHT-1) moves to DONE. A granted tool write freezes cx/cy that cycle.
  - DONE: clear_done=1 and busy=0 on the same edge, for one cycle, then IDLE. write_en carries only a tool write.
- clear_req during CLEAR or DONE is ignored and not queued.
- layer_visible never gates clear writes; invisible layers can be cleared.
- Uncontended clear: clear_req at edge k; first clear write output after k+1; last after k+WIDTH*HEIGHT; clear_done high after k+WIDTH*HEIGHT+1. Each granted tool write adds one cycle.
- write_en is 0 on every cycle with no write; write_x/write_y/write_color are don't-care then.

Test Plan:
Use WIDTH=8, HEIGHT=8, COLOR_WIDTH=4, CLEAR_COLOR=0.
1. Reset, then layer_visible=4'b0010, tool_valid with layer 2, (3,5), colour 6 -> next cycle write_en=4'b0010, x=3, y=5, colour 6, tool_dropped=0.
2. Tool_valid with layer 3 while layer_visible=4'b0010, then tool_layer=0 -> write_en=0 and tool_dropped=1 for one cycle each.
3. clear_req with clear_layer=1, no tool traffic -> 64 consecutive writes, write_en=4'b0001, raster order (0,0)..(7,7), colour 0; busy high 64 cycles; clear_done one pulse after the last write.
4. clear_all clear; tool writes to layer 2 injected at sweep positions 10 and 11 -> both dropped with tool_dropped=1, sweep never stalls, done after 64 writes. Repeat with clear_layer=1 and tool writes to visible layer 4 -> tool writes granted, sweep frozen at those positions, clear_done 2 cycles later.
5. Reset at sweep position 20 -> outputs 0 next cycle, busy=0, clear_done never asserted. A fresh clear_req restarts the sweep at (0,0).
6. clear_req with clear_layer=5 and clear_all=0 -> stays IDLE, busy=0. A second clear_req during an active clear is ignored and no extra clear_done occurs.
